// File: rtl/dmem_store_buffer_if.sv
// rtl/dmem_store_buffer_if.sv - MEM-stage request/response bundle for the data-memory store buffer
interface dmem_store_buffer_if;
    logic        MemRd;
    logic        MemWr;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        stall;
    logic        busy;

    modport master (
        output MemRd, MemWr, Addr, DataIn,
        input  DataOut, stall, busy
    );

    modport slave (
        input  MemRd, MemWr, Addr, DataIn,
        output DataOut, stall, busy
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - data memory with posted-store FIFO draining into a multi-cycle write port
// Optional feature: DMEM_STORE_FWD_EN enables load forwarding from buffered stores.
module dmem_store_buffer #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int WR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_store_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    logic [ADDR_W-1:0] buf_addr_q [DEPTH];
    logic [15:0]       buf_data_q [DEPTH];
    logic [15:0]       mem [2**ADDR_W];

    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q, state_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              busy_q, busy_d;

    logic              last_cycle, load_head, pop, mem_we, push, full;
    logic              hit, stall_c;
    logic [15:0]       hit_data, dout_c;
    logic [PW-1:0]     idx;
    logic [ADDR_W-1:0] req_addr;
    logic              unused_addr_hi;

    assign req_addr       = bus.Addr[ADDR_W-1:0];
    assign unused_addr_hi = ^bus.Addr[15:ADDR_W];
    assign full           = (count_q == CW'(DEPTH));
    assign last_cycle     = (wcnt_q == WW'(WR_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_WRITE;
                    wcnt_d  = '0;
                end
            end
            S_WRITE: begin
                wcnt_d = wcnt_q + WW'(1);
                if (last_cycle) begin
                    state_d = S_IDLE;
                    wcnt_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The head stays in the FIFO through WRITE; it leaves only on the pop edge.
    always_comb begin
        load_head = 1'b0;
        pop       = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE:  load_head = (count_q != '0);
            S_WRITE: begin
                pop    = last_cycle;
                mem_we = last_cycle;
            end
            default: ;
        endcase
    end

    // Scan oldest to youngest so the youngest matching entry ends up selected.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (buf_addr_q[idx] == req_addr)) begin
                hit      = 1'b1;
                hit_data = buf_data_q[idx];
            end
        end
    end

`ifdef DMEM_STORE_FWD_EN
    always_comb begin
        stall_c = 1'b0;
        dout_c  = '0;
        if (bus.MemWr) begin
            stall_c = full & ~pop;
        end else if (bus.MemRd) begin
            dout_c = hit ? hit_data : mem[req_addr];
        end
    end
`else
    logic unused_hit_data;
    assign unused_hit_data = ^hit_data;

    always_comb begin
        stall_c = 1'b0;
        dout_c  = '0;
        if (bus.MemWr) begin
            stall_c = full & ~pop;
        end else if (bus.MemRd) begin
            if (hit) stall_c = 1'b1;
            else     dout_c  = mem[req_addr];
        end
    end
`endif

    assign push = bus.MemWr & ~stall_c;

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        busy_d   = (count_d != '0) | (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    // Storage is never cleared; a write still in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= req_addr;
            buf_data_q[wr_ptr_q] <= bus.DataIn;
        end
        if (load_head) begin
            wr_addr_q <= buf_addr_q[rd_ptr_q];
            wr_data_q <= buf_data_q[rd_ptr_q];
        end
        if (mem_we && !reset) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    assign bus.DataOut = dout_c;
    assign bus.stall   = stall_c;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - scoreboard bench for dmem_store_buffer with a timeline-based store model
module tb_dmem_store_buffer;
    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 8;
    localparam int WR_CYCLES = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_store_buffer_if bus ();

    dmem_store_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WR_CYCLES(WR_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
        int                pop;
    } ent_t;

    typedef struct {
        int          step;
        logic        stall;
        logic        busy;
        logic [15:0] dout;
        bit          chk_dout;
    } exp_t;

    // Each pending store carries the cycle in which it leaves the buffer.
    ent_t        pend_q[$];
    exp_t        exp_q[$];
    logic [15:0] mem_m [2**ADDR_W];
    bit          mem_known [2**ADDR_W];
    int          cyc = 0;
    int          last_pop = -100;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.stall !== e.stall) begin
                n_bad++;
                $display("FAIL stall step %0d: got %b want %b", e.step, bus.stall, e.stall);
            end
            n_cmp++;
            if (bus.busy !== e.busy) begin
                n_bad++;
                $display("FAIL busy step %0d: got %b want %b", e.step, bus.busy, e.busy);
            end
            if (e.chk_dout) begin
                n_cmp++;
                if (bus.DataOut !== e.dout) begin
                    n_bad++;
                    $display("FAIL dout step %0d: got %h want %h", e.step, bus.DataOut, e.dout);
                end
            end
        end
    end

    task automatic retire();
        while (pend_q.size() > 0 && pend_q[0].pop < cyc) begin
            mem_m[pend_q[0].a]     = pend_q[0].d;
            mem_known[pend_q[0].a] = 1'b1;
            void'(pend_q.pop_front());
        end
    endtask

    task automatic step(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, output bit stalled);
        exp_t              e;
        ent_t              ne;
        logic [ADDR_W-1:0] a;
        bit                pop_now, hit;
        logic [15:0]       hd;
        int                idle_c;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        retire();
        bus.MemRd  = rd;
        bus.MemWr  = wr;
        bus.Addr   = addr;
        bus.DataIn = data;
        a          = addr[ADDR_W-1:0];
        pop_now    = (pend_q.size() > 0) && (pend_q[0].pop == cyc);
        e.step     = cyc;
        e.busy     = (pend_q.size() > 0);
        e.stall    = 1'b0;
        e.dout     = 16'h0000;
        e.chk_dout = 1'b1;
        if (wr) begin
            if (pend_q.size() == DEPTH && !pop_now) begin
                e.stall = 1'b1;
            end else begin
                idle_c = (cyc + 1 > last_pop + 1) ? cyc + 1 : last_pop + 1;
                ne.a   = a;
                ne.d   = data;
                ne.pop = idle_c + WR_CYCLES;
                last_pop = ne.pop;
                pend_q.push_back(ne);
            end
        end else if (rd) begin
            hit = 1'b0;
            hd  = 16'h0000;
            foreach (pend_q[i]) begin
                if (pend_q[i].a == a) begin
                    hit = 1'b1;
                    hd  = pend_q[i].d;
                end
            end
            if (hit) begin
`ifdef DMEM_STORE_FWD_EN
                e.dout = hd;
`else
                e.stall = 1'b1;
`endif
            end else begin
                e.dout     = mem_m[a];
                e.chk_dout = mem_known[a];
            end
        end
        stalled = e.stall;
        exp_q.push_back(e);
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] data);
        bit st;
        for (int k = 0; k < 60; k++) begin
            step(rd, wr, addr, data, st);
            if (!st) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL issue_timeout step %0d: got stalled want accepted addr %h", cyc, addr);
    endtask

    task automatic idle(input int n);
        bit st;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 16'h0, st);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        cyc++;
        retire();
        reset     = 1'b1;
        bus.MemRd = 1'b0;
        bus.MemWr = 1'b0;
        pend_q.delete();
        last_pop = -100;
    endtask

    initial begin
        bit st;
        bus.MemRd  = 1'b0;
        bus.MemWr  = 1'b0;
        bus.Addr   = 16'h0;
        bus.DataIn = 16'h0;
        idle(3);

        for (int i = 0; i < 2**ADDR_W; i++)
            issue(1'b0, 1'b1, 16'(i), 16'(i * 257) ^ 16'h5A5A);
        idle(8);

        issue(1'b0, 1'b1, 16'h0005, 16'h1234);
        idle(4);
        issue(1'b1, 1'b0, 16'h0005, 16'h0);

        issue(1'b0, 1'b1, 16'h0010, 16'hAAAA);
        issue(1'b0, 1'b1, 16'h0010, 16'hBBBB);
        issue(1'b1, 1'b0, 16'h0010, 16'h0);
        idle(8);

        for (int i = 0; i < 5; i++) issue(1'b0, 1'b1, 16'(16'h30 + i), 16'(16'hC000 + i));
        idle(20);
        for (int i = 0; i < 5; i++) issue(1'b1, 1'b0, 16'(16'h30 + i), 16'h0);

        issue(1'b0, 1'b1, 16'h0021, 16'h2121);
        idle(1);
        step(1'b1, 1'b0, 16'h0020, 16'h0, st);
        idle(4);
        issue(1'b1, 1'b0, 16'h0021, 16'h0);

        issue(1'b0, 1'b1, 16'h0007, 16'h0101);
        idle(6);
        issue(1'b0, 1'b1, 16'h0007, 16'h5555);
        idle(1);
        do_reset();
        idle(1);
        issue(1'b1, 1'b0, 16'h0007, 16'h0);

        issue(1'b0, 1'b1, 16'h1F05, 16'h7E57);
        issue(1'b1, 1'b0, 16'h0005, 16'h0);
        idle(5);
        issue(1'b1, 1'b0, 16'hA305, 16'h0);

        for (int i = 0; i < 1500; i++) begin
            int op;
            logic [15:0] ad;
            op = int'($urandom_range(0, 99));
            ad = {8'($urandom), 8'($urandom_range(0, 15))};
            if (op < 2)       do_reset();
            else if (op < 30) idle(1);
            else if (op < 65) issue(1'b1, 1'b0, ad, 16'h0);
            else              issue(1'b0, 1'b1, ad, 16'($urandom));
        end
        idle(12);
        for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, 16'(i), 16'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
